// File: rtl/vga_scaled_reader.sv
// VGA raster generator and scaled frame-buffer reader with latency-matched sync/colour outputs.
// Optional build macro VGA_BORDER_EN: forces a white frame on the outermost active rows/columns.
module vga_scaled_reader #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   SCALE_LOG2 = 1,
    parameter int   MEM_LAT    = 1,
    parameter int   ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_vsync,
    output logic [ADDR_W-1:0] read_add,
    output logic              read_en,
    input  logic [11:0]       read_data,
    output logic [3:0]        red,
    output logic [3:0]        grn,
    output logic [3:0]        blu,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST_C      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C      = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_START_C = HW'(H_ACT_START);
    localparam logic [HW-1:0] H_ACT_END_C   = HW'(H_ACT_START + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C      = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_START_C = VW'(V_ACT_START);
    localparam logic [VW-1:0] V_ACT_END_C   = VW'(V_ACT_START + V_ACTIVE);
    localparam logic [VW-1:0] REP_MASK_C    = VW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] SRC_W_C   = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

`ifdef VGA_BORDER_EN
    localparam logic [HW-1:0] H_ACT_LAST_C  = HW'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_ACT_LAST_C  = VW'(V_ACT_START + V_ACTIVE - 1);
    localparam int PW = 5;
`else
    localparam int PW = 4;
`endif

    // Stage word layout: [0] hsync, [1] vsync, [2] de, [3] frame_start, [4] border (optional)
    localparam logic [PW-1:0] STAGE_IDLE = PW'({~VS_POL, ~HS_POL});

    logic [HW-1:0]     hcnt_reg;
    logic [VW-1:0]     vcnt_reg;
    logic [ADDR_W-1:0] line_base_reg;
    logic [ADDR_W-1:0] read_add_reg;
    logic              read_en_reg;
    logic [PW-1:0]     stage_reg;
    logic [PW-1:0]     stage_next;
    logic [PW-1:0]     pipe_out;
    logic              hsync_reg;
    logic              vsync_reg;
    logic              de_reg;
    logic              frame_start_reg;
    logic [11:0]       rgb_reg;

    logic              h_last;
    logic              h_active;
    logic              v_active;
    logic              active;
    logic [HW-1:0]     h_rel;
    logic [VW-1:0]     v_rel;
    logic [ADDR_W-1:0] x_off;

    assign h_last   = (hcnt_reg == H_LAST_C);
    assign h_active = (hcnt_reg >= H_ACT_START_C) && (hcnt_reg < H_ACT_END_C);
    assign v_active = (vcnt_reg >= V_ACT_START_C) && (vcnt_reg < V_ACT_END_C);
    assign active   = h_active && v_active;
    assign h_rel    = hcnt_reg - H_ACT_START_C;
    assign v_rel    = vcnt_reg - V_ACT_START_C;
    assign x_off    = ADDR_W'(h_rel >> SCALE_LOG2);

    always_ff @(posedge clk) begin
        if (rst || sync_vsync) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (h_last) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == V_LAST_C) ? '0 : vcnt_reg + 1'b1;
        end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
        end
    end

    // Row base advances once every 2^S output lines, replacing y*SRC_W
    always_ff @(posedge clk) begin
        if (rst || sync_vsync || (vcnt_reg == '0)) begin
            line_base_reg <= '0;
        end else if (h_last && v_active && ((v_rel & REP_MASK_C) == REP_MASK_C)) begin
            line_base_reg <= line_base_reg + SRC_W_C;
        end
    end

    always_comb begin
        stage_next    = STAGE_IDLE;
        stage_next[0] = (hcnt_reg < H_SYNC_C) ? HS_POL : ~HS_POL;
        stage_next[1] = (vcnt_reg < V_SYNC_C) ? VS_POL : ~VS_POL;
        stage_next[2] = active;
        stage_next[3] = (hcnt_reg == '0) && (vcnt_reg == '0);
`ifdef VGA_BORDER_EN
        stage_next[4] = active && ((hcnt_reg == H_ACT_START_C) || (hcnt_reg == H_ACT_LAST_C) ||
                                   (vcnt_reg == V_ACT_START_C) || (vcnt_reg == V_ACT_LAST_C));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_en_reg  <= 1'b0;
            read_add_reg <= '0;
            stage_reg    <= STAGE_IDLE;
        end else if (sync_vsync) begin
            read_en_reg  <= 1'b0;
            stage_reg    <= STAGE_IDLE;
        end else begin
            read_en_reg  <= active;
            if (active) begin
                read_add_reg <= line_base_reg + x_off;
            end
            stage_reg    <= stage_next;
        end
    end

    // Control flags travel alongside the memory read so they meet read_data on the same cycle
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_dly
            logic [PW-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst || sync_vsync) q_reg <= STAGE_IDLE;
                    else                   q_reg <= stage_reg;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (rst || sync_vsync) q_reg <= STAGE_IDLE;
                    else                   q_reg <= g_dly[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign pipe_out = g_dly[MEM_LAT-1].q_reg;

    always_ff @(posedge clk) begin
        if (rst || sync_vsync) begin
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            de_reg          <= 1'b0;
            frame_start_reg <= 1'b0;
            rgb_reg         <= '0;
        end else begin
            hsync_reg       <= pipe_out[0];
            vsync_reg       <= pipe_out[1];
            de_reg          <= pipe_out[2];
            frame_start_reg <= pipe_out[3];
            if (!pipe_out[2]) begin
                rgb_reg <= '0;
`ifdef VGA_BORDER_EN
            end else if (pipe_out[4]) begin
                rgb_reg <= 12'hFFF;
`endif
            end else begin
                rgb_reg <= read_data;
            end
        end
    end

    assign read_add    = read_add_reg;
    assign read_en     = read_en_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign frame_start = frame_start_reg;
    assign red         = rgb_reg[3:0];
    assign grn         = rgb_reg[7:4];
    assign blu         = rgb_reg[11:8];

endmodule

// File: tb/tb_vga_scaled_reader.sv
// Randomised bench for vga_scaled_reader: a frame-time model predicts every output each cycle.
module tb_vga_scaled_reader;

    localparam int   H_ACTIVE   = 32;
    localparam int   H_FP       = 4;
    localparam int   H_SYNC     = 6;
    localparam int   H_BP       = 5;
    localparam int   V_ACTIVE   = 16;
    localparam int   V_FP       = 2;
    localparam int   V_SYNC     = 2;
    localparam int   V_BP       = 3;
    localparam logic HS_POL     = 1'b0;
    localparam logic VS_POL     = 1'b1;
    localparam int   SCALE_LOG2 = 1;
    localparam int   MEM_LAT    = 2;
    localparam int   ADDR_W     = 10;
    localparam int   HT         = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int   VT         = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int   FRAME      = HT * VT;
    localparam int   SRC_W      = H_ACTIVE >> SCALE_LOG2;
    localparam int   NCYC       = 7000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync_vsync = 1'b0;
    logic [ADDR_W-1:0] read_add;
    logic              read_en;
    logic [11:0]       read_data;
    logic [3:0]        red, grn, blu;
    logic              hsync, vsync, de, frame_start;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_scaled_reader #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .SCALE_LOG2(SCALE_LOG2),
        .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .sync_vsync(sync_vsync),
        .read_add(read_add), .read_en(read_en), .read_data(read_data),
        .red(red), .grn(grn), .blu(blu),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    function automatic logic [11:0] pattern(input logic [ADDR_W-1:0] a);
        logic [11:0] w;
        w = {2'b00, a};
        return (w * 12'd13) ^ 12'h5A3;
    endfunction

    // Video RAM model: synchronous read with MEM_LAT cycles of latency
    logic [11:0] rd_pipe [MEM_LAT] = '{default: 12'h000};
    always @(posedge clk) begin
        rd_pipe[0] <= read_en ? pattern(read_add) : 12'h000;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_data = rd_pipe[MEM_LAT-1];

    function automatic int hof(input int t); return t % HT; endfunction
    function automatic int vof(input int t); return t / HT; endfunction

    function automatic bit act(input int t);
        return (hof(t) >= H_SYNC + H_BP) && (hof(t) < H_SYNC + H_BP + H_ACTIVE) &&
               (vof(t) >= V_SYNC + V_BP) && (vof(t) < V_SYNC + V_BP + V_ACTIVE);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int t);
        int x, y;
        x = (hof(t) - H_SYNC - H_BP) >> SCALE_LOG2;
        y = (vof(t) - V_SYNC - V_BP) >> SCALE_LOG2;
        return ADDR_W'(y * SRC_W + x);
    endfunction

    function automatic bit on_border(input int t);
        int x, y;
        x = hof(t) - H_SYNC - H_BP;
        y = vof(t) - V_SYNC - V_BP;
        return (x == 0) || (x == H_ACTIVE - 1) || (y == 0) || (y == V_ACTIVE - 1);
    endfunction

    // pos_t: frame time of the counter state; hist[k]: frame time feeding a stage k+1 edges ago (-1 = flushed)
    int pos_t = 0;
    int hist [MEM_LAT+2] = '{default: -1};
    logic [ADDR_W-1:0] exp_add = '0;

    task automatic model_step(input logic r, input logic s);
        if (r || s) begin
            for (int i = 0; i < MEM_LAT + 2; i++) hist[i] = -1;
            if (r) exp_add = '0;
            pos_t = 0;
        end else begin
            for (int i = MEM_LAT + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pos_t;
            if (act(pos_t)) exp_add = addr_of(pos_t);
            pos_t = (pos_t + 1) % FRAME;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        int o;
        logic e_en, e_hs, e_vs, e_de, e_fs;
        logic [11:0] e_rgb;
        o    = hist[MEM_LAT+1];
        e_en = (hist[0] >= 0) && act(hist[0]);
        e_hs = (o >= 0 && hof(o) < H_SYNC) ? HS_POL : !HS_POL;
        e_vs = (o >= 0 && vof(o) < V_SYNC) ? VS_POL : !VS_POL;
        e_de = (o >= 0) && act(o);
        e_fs = (o == 0);
        e_rgb = 12'h000;
        if (e_de) begin
`ifdef VGA_BORDER_EN
            e_rgb = on_border(o) ? 12'hFFF : pattern(addr_of(o));
`else
            e_rgb = pattern(addr_of(o));
`endif
        end
        check("read_en", 32'(read_en), 32'(e_en));
        check("read_add", 32'(read_add), 32'(exp_add));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("de", 32'(de), 32'(e_de));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("colour", 32'({blu, grn, red}), 32'(e_rgb));
    endtask

    initial begin
        bit sync_done;
        bit rst_done;
        sync_done = 1'b0;
        rst_done  = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_step(rst, sync_vsync);
            rst        = 1'b0;
            sync_vsync = 1'b0;
            if (c < 3) rst = 1'b1;
            // Directed restart mid-line at row 12, then a one-cycle reset mid-active-line
            if (!sync_done && c > 2000 && vof(pos_t) == 12 && hof(pos_t) == 20) begin
                sync_vsync = 1'b1;
                sync_done  = 1'b1;
            end
            if (!rst_done && c > 4000 && vof(pos_t) == 9 && hof(pos_t) == 25) begin
                rst      = 1'b1;
                rst_done = 1'b1;
            end
            if (c > 5000 && $urandom_range(0, 1499) == 0) sync_vsync = 1'b1;
            if (c > 5000 && $urandom_range(0, 2999) == 0) rst = 1'b1;
            if (c == 6500) begin
                rst        = 1'b1;
                sync_vsync = 1'b1;
            end
            @(negedge clk);
            cyc = c;
            compare_all();
        end
        check("directed_sync_seen", 32'(sync_done), 32'd1);
        check("directed_rst_seen", 32'(rst_done), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
